// File: rtl/mmcm0_drp_reconfig_if.sv
// Request, DRP and MMCM control bundle between the reconfig controller and its environment.
// master is the controller side; slave is the MMCM/DRP/requester side.
interface mmcm0_drp_reconfig_if;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  req_mult;
   logic [6:0]  req_div0;
   logic [6:0]  req_div1;
   logic [6:0]  drp_daddr;
   logic        drp_den;
   logic        drp_dwe;
   logic [15:0] drp_di;
   logic [15:0] drp_do;
   logic        drp_drdy;
   logic        mmcm_rst;
   logic        mmcm_locked;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      input  req_valid, req_mult, req_div0, req_div1, drp_do, drp_drdy, mmcm_locked,
      output req_ready, drp_daddr, drp_den, drp_dwe, drp_di, mmcm_rst, busy, done, error
   );

   modport slave (
      output req_valid, req_mult, req_div0, req_div1, drp_do, drp_drdy, mmcm_locked,
      input  req_ready, drp_daddr, drp_den, drp_dwe, drp_di, mmcm_rst, busy, done, error
   );
endinterface

// File: rtl/mmcm0_drp_reconfig.sv
// Runtime rewrite of MMCM CLKFBOUT/CLKOUT0/CLKOUT1 integer dividers over DRP, with the MMCM
// reset/lock handshake sequenced around each rewrite and after power-up.
module mmcm0_drp_reconfig #(
   parameter int          DRDY_TIMEOUT = 64,
   parameter int          LOCK_TIMEOUT = 65535,
   parameter logic [15:0] MASK_REG1    = 16'h1000,
   parameter logic [15:0] MASK_REG2    = 16'hFC00
) (
   input  logic                 clk_in0,
   input  logic                 reset,
   mmcm0_drp_reconfig_if.master bus
);
   localparam logic [3:0] S_RELEASE    = 4'd0;
   localparam logic [3:0] S_WAIT_LOCK  = 4'd1;
   localparam logic [3:0] S_IDLE       = 4'd2;
   localparam logic [3:0] S_CHECK      = 4'd3;
   localparam logic [3:0] S_ASSERT_RST = 4'd4;
   localparam logic [3:0] S_RD         = 4'd5;
   localparam logic [3:0] S_RD_WAIT    = 4'd6;
   localparam logic [3:0] S_WR         = 4'd7;
   localparam logic [3:0] S_WR_WAIT    = 4'd8;
   localparam logic [3:0] S_DONE       = 4'd9;
   localparam logic [3:0] S_ERR        = 4'd10;

   localparam int DW = $clog2(DRDY_TIMEOUT + 1);
   localparam int LW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [DW-1:0] DRDY_LAST = DW'(DRDY_TIMEOUT - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

   logic [3:0]    state, state_nx;
   logic [6:0]    mult, div0, div1;
   logic [2:0]    idx;
   logic [15:0]   rd_data;
   logic [DW-1:0] drdy_cnt;
   logic [LW-1:0] lock_cnt;
   logic          reconfig;
   logic          rst_q;

   logic          waiting, drdy_hit, drdy_expired, illegal;
   logic [6:0]    dsel, addr_v;
   logic          one;
   logic [5:0]    high_v, low_v;
   logic          edge_bit;
   logic [15:0]   merged;

   assign waiting      = (state == S_RD_WAIT) || (state == S_WR_WAIT);
   assign drdy_hit     = waiting && bus.drp_drdy;
   assign drdy_expired = waiting && !bus.drp_drdy && (drdy_cnt == DRDY_LAST);
   assign illegal      = (mult < 7'd2) || (mult > 7'd126) || (div0 == 7'd0) || (div1 == 7'd0);

   // Even indices hit ClkReg1, odd ones ClkReg2 of the same output.
   always_comb begin
      dsel   = mult;
      addr_v = 7'h15;
      case (idx[2:1])
         2'd0:    dsel = div0;
         2'd1:    dsel = div1;
         default: dsel = mult;
      endcase
      case (idx)
         3'd0:    addr_v = 7'h08;
         3'd1:    addr_v = 7'h09;
         3'd2:    addr_v = 7'h0A;
         3'd3:    addr_v = 7'h0B;
         3'd4:    addr_v = 7'h14;
         default: addr_v = 7'h15;
      endcase
   end

   // Divide-by-1 bypasses the counter; otherwise split into high/low with odd rounding on edge.
   assign one      = (dsel == 7'd1);
   assign high_v   = one ? 6'd1 : dsel[6:1];
   assign low_v    = one ? 6'd1 : 6'(dsel - {1'b0, dsel[6:1]});
   assign edge_bit = !one && dsel[0];
   assign merged   = idx[0] ? ((rd_data & MASK_REG2) | {8'h00, edge_bit, one, 6'b000000})
                            : ((rd_data & MASK_REG1) | {4'b0000, high_v, low_v});

   always_comb begin
      state_nx = state;
      case (state)
         S_RELEASE:    state_nx = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (bus.mmcm_locked)          state_nx = reconfig ? S_DONE : S_IDLE;
            else if (lock_cnt == LOCK_LAST) state_nx = S_ERR;
         end
         S_IDLE:       if (bus.req_valid) state_nx = S_CHECK;
         S_CHECK:      state_nx = illegal ? S_ERR : S_ASSERT_RST;
         S_ASSERT_RST: state_nx = S_RD;
         S_RD:         state_nx = S_RD_WAIT;
         S_RD_WAIT: begin
            if (drdy_hit)          state_nx = S_WR;
            else if (drdy_expired) state_nx = S_ERR;
         end
         S_WR:         state_nx = S_WR_WAIT;
         S_WR_WAIT: begin
            if (drdy_hit)          state_nx = (idx == 3'd5) ? S_RELEASE : S_RD;
            else if (drdy_expired) state_nx = S_ERR;
         end
         S_DONE:       state_nx = S_IDLE;
         S_ERR:        state_nx = S_IDLE;
         default:      state_nx = S_RELEASE;
      endcase
   end

   always_ff @(posedge clk_in0) begin
      if (reset) begin
         state    <= S_RELEASE;
         rst_q    <= 1'b1;
         mult     <= '0;
         div0     <= '0;
         div1     <= '0;
         idx      <= '0;
         rd_data  <= '0;
         drdy_cnt <= '0;
         lock_cnt <= '0;
         reconfig <= 1'b0;
      end else begin
         state <= state_nx;

         // Reset stays up across a DRDY timeout so the MMCM never runs on half-written settings.
         if (state_nx == S_ASSERT_RST)
            rst_q <= 1'b1;
         else if (state == S_RELEASE || state_nx == S_RELEASE)
            rst_q <= 1'b0;

         if (state == S_IDLE && bus.req_valid) begin
            mult <= bus.req_mult;
            div0 <= bus.req_div0;
            div1 <= bus.req_div1;
         end

         if (state == S_ASSERT_RST)
            idx <= 3'd0;
         else if (state == S_WR_WAIT && drdy_hit)
            idx <= idx + 3'd1;

         if (state == S_RD_WAIT && drdy_hit)
            rd_data <= bus.drp_do;

         if (state == S_RD || state == S_WR)
            drdy_cnt <= '0;
         else if (waiting)
            drdy_cnt <= drdy_cnt + 1'b1;

         if (state == S_WAIT_LOCK)
            lock_cnt <= lock_cnt + 1'b1;
         else
            lock_cnt <= '0;

         if (state == S_ASSERT_RST)
            reconfig <= 1'b1;
         else if (state == S_IDLE || state == S_ERR || state == S_DONE)
            reconfig <= 1'b0;
      end
   end

   assign bus.req_ready = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.error     = (state == S_ERR);
   assign bus.drp_den   = (state == S_RD) || (state == S_WR);
   assign bus.drp_dwe   = (state == S_WR);
   assign bus.drp_daddr = (bus.drp_den || waiting) ? addr_v : 7'd0;
   assign bus.drp_di    = (state == S_WR) ? merged : 16'd0;
   assign bus.mmcm_rst  = rst_q;
endmodule
